// File: rtl/match_referee.sv
// Rally/score controller: scores points, counts touches per side, tracks serve side and sequences serve/pause/game-over.
// Outputs are registered, so an event sampled in cycle N shows up in cycle N+1.
module match_referee #(
   parameter int POINTS_TO_WIN = 15,
   parameter int MAX_TOUCHES   = 3,
   parameter int NET_X         = 512,
   parameter int GROUND_Y      = 700,
   parameter int PAUSE_CYCLES  = 65000000,
   parameter int SCORE_W       = 5,
   localparam int TC_W         = $clog2(MAX_TOUCHES + 2)
) (
   input  logic               pclk,
   input  logic               rst,
   input  logic               start,
   input  logic [11:0]        ball_xpos,
   input  logic [11:0]        ball_ypos,
   input  logic               pl1_col,
   input  logic               pl2_col,
   output logic [SCORE_W-1:0] score_player1,
   output logic [SCORE_W-1:0] score_player2,
   output logic [TC_W-1:0]    touch_count,
   output logic               last_touch,
   output logic               serve_side,
   output logic               flag_point,
   output logic               ball_reset,
   output logic               rally_active,
   output logic               endgame,
   output logic               winner
);

   localparam int CNT_W = $clog2(PAUSE_CYCLES + 1);

   localparam logic [11:0]        NET_X_L    = 12'(NET_X);
   localparam logic [11:0]        GROUND_Y_L = 12'(GROUND_Y);
   localparam logic [TC_W-1:0]    MAX_T      = TC_W'(MAX_TOUCHES);
   localparam logic [SCORE_W-1:0] WIN_SCORE  = SCORE_W'(POINTS_TO_WIN);
   localparam logic [CNT_W-1:0]   PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, SERVE, RALLY, PAUSE, GAME_OVER} state_t;

   state_t             state;
   logic [CNT_W-1:0]   pause_cnt;
   logic               pl1_prev;
   logic               pl2_prev;

   logic               pl1_edge;
   logic               pl2_edge;
   logic               ground;
   logic               ground_side;
   logic               touch_vld;
   logic               touch_side;
   logic               same_side;
   logic [TC_W-1:0]    tc_inc;
   logic               fault;
   logic               point_vld;
   logic               point_side;
   logic [SCORE_W-1:0] score_next;
   logic               match_won;

   assign pl1_edge    = pl1_col & ~pl1_prev;
   assign pl2_edge    = pl2_col & ~pl2_prev;
   assign ground      = (ball_ypos >= GROUND_Y_L);
   // Ball landing in the player-1 half is a point for player 2.
   assign ground_side = (ball_xpos < NET_X_L);
   assign touch_vld   = pl1_edge | pl2_edge;
   assign touch_side  = ~pl1_edge;
   assign same_side   = (touch_side == last_touch) && (touch_count != '0);
   assign tc_inc      = touch_count + TC_W'(1);
   assign fault       = touch_vld && same_side && (tc_inc > MAX_T);
   assign point_vld   = ground | fault;
   assign point_side  = ground ? ground_side : ~touch_side;
   assign score_next  = (point_side ? score_player2 : score_player1) + SCORE_W'(1);
   assign match_won   = (score_next == WIN_SCORE);

   always_ff @(posedge pclk) begin
      if (rst) begin
         state         <= IDLE;
         pause_cnt     <= '0;
         pl1_prev      <= 1'b0;
         pl2_prev      <= 1'b0;
         score_player1 <= '0;
         score_player2 <= '0;
         touch_count   <= '0;
         last_touch    <= 1'b0;
         serve_side    <= 1'b0;
         flag_point    <= 1'b0;
         ball_reset    <= 1'b0;
         rally_active  <= 1'b0;
         endgame       <= 1'b0;
         winner        <= 1'b0;
      end else begin
         pl1_prev   <= pl1_col;
         pl2_prev   <= pl2_col;
         flag_point <= 1'b0;
         ball_reset <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= SERVE;
                  ball_reset  <= 1'b1;
                  touch_count <= '0;
                  last_touch  <= serve_side;
               end
            end
            SERVE: begin
               state        <= RALLY;
               rally_active <= 1'b1;
            end
            RALLY: begin
               if (point_vld) begin
                  flag_point   <= 1'b1;
                  serve_side   <= point_side;
                  rally_active <= 1'b0;
                  if (point_side) score_player2 <= score_next;
                  else            score_player1 <= score_next;
                  if (match_won) begin
                     state   <= GAME_OVER;
                     endgame <= 1'b1;
                     winner  <= point_side;
                  end else begin
                     state     <= PAUSE;
                     pause_cnt <= '0;
                  end
               end
               // A ground hit masks any touch in the same cycle.
               if (touch_vld && !ground) begin
                  if (same_side) begin
                     touch_count <= tc_inc;
                  end else begin
                     last_touch  <= touch_side;
                     touch_count <= TC_W'(1);
                  end
               end
            end
            PAUSE: begin
               if (pause_cnt == PAUSE_LAST) begin
                  state       <= SERVE;
                  ball_reset  <= 1'b1;
                  touch_count <= '0;
                  last_touch  <= serve_side;
               end else begin
                  pause_cnt <= pause_cnt + CNT_W'(1);
               end
            end
            GAME_OVER: begin
               if (start) begin
                  state         <= SERVE;
                  endgame       <= 1'b0;
                  score_player1 <= '0;
                  score_player2 <= '0;
                  touch_count   <= '0;
                  serve_side    <= ~winner;
                  last_touch    <= ~winner;
                  ball_reset    <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_match_referee.sv
// Directed bench for match_referee: a behavioural referee model checked every cycle plus literal expectations.
module tb_match_referee;

   localparam int P2W   = 3;
   localparam int MAXT  = 3;
   localparam int PAUSE = 4;
   localparam int NETX  = 512;
   localparam int GNDY  = 700;
   localparam int TC_W  = $clog2(MAXT + 2);

   logic            pclk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [11:0]     ball_xpos = 12'd100;
   logic [11:0]     ball_ypos = 12'd100;
   logic            pl1_col = 1'b0;
   logic            pl2_col = 1'b0;
   logic [4:0]      score_player1;
   logic [4:0]      score_player2;
   logic [TC_W-1:0] touch_count;
   logic            last_touch;
   logic            serve_side;
   logic            flag_point;
   logic            ball_reset;
   logic            rally_active;
   logic            endgame;
   logic            winner;

   match_referee #(
      .POINTS_TO_WIN(P2W), .MAX_TOUCHES(MAXT), .NET_X(NETX),
      .GROUND_Y(GNDY), .PAUSE_CYCLES(PAUSE), .SCORE_W(5)
   ) dut (
      .pclk(pclk), .rst(rst), .start(start),
      .ball_xpos(ball_xpos), .ball_ypos(ball_ypos),
      .pl1_col(pl1_col), .pl2_col(pl2_col),
      .score_player1(score_player1), .score_player2(score_player2),
      .touch_count(touch_count), .last_touch(last_touch),
      .serve_side(serve_side), .flag_point(flag_point),
      .ball_reset(ball_reset), .rally_active(rally_active),
      .endgame(endgame), .winner(winner)
   );

   always #5 pclk = ~pclk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Referee model: phase 0 idle, 1 serve, 2 rally, 3 pause, 4 game over.
   int m_phase, m_s[2], m_tc, m_last, m_serve, m_flag, m_br, m_win, m_left;
   int m_p1, m_p2;

   function automatic void award(input int w);
      m_s[w]++;
      m_flag  = 1;
      m_serve = w;
      if (m_s[w] == P2W) begin
         m_phase = 4;
         m_win   = w;
      end else begin
         m_phase = 3;
         m_left  = PAUSE;
      end
   endfunction

   function automatic void begin_serve();
      m_phase = 1;
      m_br    = 1;
      m_tc    = 0;
      m_last  = m_serve;
   endfunction

   always @(posedge pclk) begin
      int e1, e2, side;
      if (rst) begin
         m_phase = 0; m_s[0] = 0; m_s[1] = 0; m_tc = 0; m_last = 0; m_serve = 0;
         m_flag = 0; m_br = 0; m_win = 0; m_left = 0; m_p1 = 0; m_p2 = 0;
      end else begin
         e1 = (pl1_col && m_p1 == 0) ? 1 : 0;
         e2 = (pl2_col && m_p2 == 0) ? 1 : 0;
         m_p1 = int'(pl1_col);
         m_p2 = int'(pl2_col);
         m_flag = 0;
         m_br   = 0;
         case (m_phase)
            0: if (start) begin_serve();
            1: m_phase = 2;
            2: begin
               if (int'(ball_ypos) >= GNDY) begin
                  award(int'(ball_xpos) < NETX ? 1 : 0);
               end else if (e1 == 1 || e2 == 1) begin
                  side = (e1 == 1) ? 0 : 1;
                  if (side == m_last && m_tc > 0) begin
                     m_tc++;
                     if (m_tc > MAXT) award(1 - side);
                  end else begin
                     m_last = side;
                     m_tc   = 1;
                  end
               end
            end
            3: begin
               m_left--;
               if (m_left == 0) begin_serve();
            end
            default: if (start) begin
               m_s[0] = 0; m_s[1] = 0;
               m_serve = 1 - m_win;
               begin_serve();
            end
         endcase
      end
   end

   always @(negedge pclk) begin
      if (chk_en) begin
         chk("score_player1", int'(score_player1), m_s[0]);
         chk("score_player2", int'(score_player2), m_s[1]);
         chk("touch_count", int'(touch_count), m_tc);
         chk("last_touch", int'(last_touch), m_last);
         chk("serve_side", int'(serve_side), m_serve);
         chk("flag_point", int'(flag_point), m_flag);
         chk("ball_reset", int'(ball_reset), m_br);
         chk("rally_active", int'(rally_active), m_phase == 2 ? 1 : 0);
         chk("endgame", int'(endgame), m_phase == 4 ? 1 : 0);
         chk("winner", int'(winner), m_win);
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge pclk);
      #2;
   endtask

   task automatic touch(input bit p2);
      if (p2) pl2_col = 1'b1; else pl1_col = 1'b1;
      step();
   endtask

   task automatic release_cols();
      pl1_col = 1'b0;
      pl2_col = 1'b0;
      step();
   endtask

   task automatic ground_hit(input int x);
      ball_xpos = 12'(x);
      ball_ypos = 12'(GNDY);
      step();
      ball_ypos = 12'd100;
   endtask

   task automatic wait_rally();
      for (int i = 0; i < 20; i++) begin
         if (rally_active) break;
         step();
      end
      chk("wait_rally", int'(rally_active), 1);
   endtask

   initial begin
      step(3);
      chk_en = 1'b1;
      rst = 1'b0;
      chk("rst_score1", int'(score_player1), 0);
      chk("rst_ball_reset", int'(ball_reset), 0);
      chk("rst_rally", int'(rally_active), 0);

      start = 1'b1; step(); start = 1'b0;
      chk("serve_ball_reset", int'(ball_reset), 1);
      chk("serve_rally", int'(rally_active), 0);
      step();
      chk("rally_on", int'(rally_active), 1);
      chk("rally_ball_reset", int'(ball_reset), 0);

      ground_hit(300);
      chk("gnd_flag", int'(flag_point), 1);
      chk("gnd_score2", int'(score_player2), 1);
      chk("gnd_serve", int'(serve_side), 1);
      step(3);
      chk("pause_no_reset", int'(ball_reset), 0);
      step();
      chk("respawn", int'(ball_reset), 1);
      step();

      for (int k = 1; k <= 3; k++) begin
         touch(1'b0);
         chk("touch_cnt", int'(touch_count), k);
         release_cols();
      end
      touch(1'b0);
      chk("fault_flag", int'(flag_point), 1);
      chk("fault_score2", int'(score_player2), 2);
      release_cols();
      wait_rally();

      pl1_col = 1'b1;
      step(100);
      chk("hold_one_touch", int'(touch_count), 1);
      release_cols();

      touch(1'b0); release_cols();
      touch(1'b0); release_cols();
      touch(1'b1); release_cols();
      chk("switch_last", int'(last_touch), 1);
      chk("switch_cnt", int'(touch_count), 1);
      chk("switch_noscore", int'(score_player2), 2);

      pl1_col = 1'b1;
      ground_hit(600);
      chk("both_flag", int'(flag_point), 1);
      chk("both_score1", int'(score_player1), 1);
      chk("both_cnt", int'(touch_count), 1);
      release_cols();

      wait_rally(); ground_hit(600);
      wait_rally(); ground_hit(600);
      chk("over_end", int'(endgame), 1);
      chk("over_winner", int'(winner), 0);
      chk("over_score1", int'(score_player1), 3);
      step(2);
      ground_hit(100); step();
      chk("over_frozen2", int'(score_player2), 2);
      chk("over_noflag", int'(flag_point), 0);

      start = 1'b1; step(); start = 1'b0;
      chk("restart_s1", int'(score_player1), 0);
      chk("restart_serve", int'(serve_side), 1);
      chk("restart_reset", int'(ball_reset), 1);
      chk("restart_end", int'(endgame), 0);

      wait_rally(); ground_hit(100);
      step();
      rst = 1'b1; step(); rst = 1'b0;
      chk("rst_pause_rally", int'(rally_active), 0);
      chk("rst_pause_s2", int'(score_player2), 0);
      for (int k = 0; k < 6; k++) begin
         chk("rst_pause_no_reset", int'(ball_reset), 0);
         step();
      end
      start = 1'b1; step(); start = 1'b0;
      chk("idle_serve", int'(ball_reset), 1);
      step(2);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
